bht_controller: RTL and testbench

BHT_CONTROLLER -- requirements
Module: bht_controller

---
 rtl/bht_controller_pkg.sv | 14 +
 rtl/bht_controller_sat_counter2.sv | 21 ++
 rtl/bht_controller.sv | 108 ++++++++++
 tb/tb_bht_controller.sv | 289 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bht_controller_pkg.sv
// Shared constants and FSM encoding for the
// branch history table controller.
package bht_controller_pkg;

  typedef enum logic {
    S_INIT = 1'b0,
    S_RUN  = 1'b1
  } state_t;

  localparam logic [5:0] OP_BEQ    = 6'b000100;
  localparam logic [1:0] CNT_INIT  = 2'b01;
  localparam logic [1:0] CNT_TAKEN = 2'b10;

endpackage

// File: rtl/bht_controller_sat_counter2.sv
// Two-bit saturating counter next-value logic.
// Ports: counter/taken in, next_counter out.
module sat_counter2 (
  input  logic [1:0] counter,
  input  logic       taken,
  output logic [1:0] next_counter
);

  always_comb begin
    next_counter = counter;
    unique case (1'b1)
      (taken && counter != 2'b11):
        next_counter = counter + 2'd1;
      (!taken && counter != 2'b00):
        next_counter = counter - 2'd1;
      default:
        next_counter = counter;
    endcase
  end

endmodule

// File: rtl/bht_controller.sv
// Branch history table: 2-bit counters, init walk,
// lookup/predict, update, mispredict pulse/count.
// Ports: clk, rst_n, clr; lookup_pc/ins -> predict,
// pred_state; upd_* -> mispredict, miss_cnt; ready.
module bht_controller
  import bht_controller_pkg::*;
#(
  parameter int ENTRIES = 16,
  parameter int IDX_W   = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic [31:0] lookup_pc,
  input  logic [31:0] lookup_ins,
  output logic        predict,
  output logic [1:0]  pred_state,
  input  logic        upd_valid,
  input  logic [31:0] upd_pc,
  input  logic        upd_taken,
  input  logic        upd_predicted,
  output logic        mispredict,
  output logic        ready,
  output logic [15:0] miss_cnt
);

  state_t             state;
  logic [IDX_W-1:0]   init_idx;
  logic [1:0]         tbl [ENTRIES];
  logic [IDX_W-1:0]   lk_idx;
  logic [IDX_W-1:0]   up_idx;
  logic [1:0]         rd;
  logic [1:0]         up_nxt;
  logic               run;
  logic               accept;
  logic               wrong;
  logic               unused_ok;

  assign lk_idx = lookup_pc[IDX_W+1:2];
  assign up_idx = upd_pc[IDX_W+1:2];
  assign run    = (state == S_RUN);
  // clr in RUN takes priority and drops the update
  assign accept = run && upd_valid && !clr;
  assign wrong  = (upd_taken != upd_predicted);
  assign rd     = tbl[lk_idx];

  assign unused_ok = ^{lookup_pc[31:IDX_W+2],
                       lookup_pc[1:0],
                       upd_pc[31:IDX_W+2],
                       upd_pc[1:0],
                       lookup_ins[25:0]};

  assign ready      = run;
  assign pred_state = run ? rd : 2'b00;
  assign predict    = run &&
                      (lookup_ins[31:26] == OP_BEQ) &&
                      (rd >= CNT_TAKEN);

  sat_counter2 u_sat (
    .counter      (tbl[up_idx]),
    .taken        (upd_taken),
    .next_counter (up_nxt)
  );

  // Table has no reset; the INIT walk defines it.
  always_ff @(posedge clk) begin
    if (!run)
      tbl[init_idx] <= CNT_INIT;
    else if (accept)
      tbl[up_idx] <= up_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_INIT;
      init_idx   <= '0;
      mispredict <= 1'b0;
      miss_cnt   <= '0;
    end else begin
      mispredict <= accept && wrong;
      unique case (state)
        S_INIT: begin
          if (clr) begin
            init_idx <= '0;
          end else if (init_idx ==
                       IDX_W'(ENTRIES - 1)) begin
            init_idx <= '0;
            state    <= S_RUN;
          end else begin
            init_idx <= init_idx + 1'b1;
          end
        end
        S_RUN: begin
          if (clr) begin
            state    <= S_INIT;
            init_idx <= '0;
            miss_cnt <= '0;
          end else if (accept && wrong &&
                       miss_cnt != 16'hFFFF) begin
            miss_cnt <= miss_cnt + 16'd1;
          end
        end
        default: state <= S_INIT;
      endcase
    end
  end

endmodule

// File: tb/tb_bht_controller.sv
// Directed self-checking bench for bht_controller.
// One task per scenario, inline comparisons.
module tb_bht_controller;

  localparam logic [31:0] INS_BEQ = 32'h1000_0000;
  localparam logic [31:0] INS_J   = 32'h0800_0000;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        clr = 1'b0;
  logic [31:0] lookup_pc = '0;
  logic [31:0] lookup_ins = '0;
  logic        predict;
  logic [1:0]  pred_state;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic        upd_predicted = 1'b0;
  logic        mispredict;
  logic        ready;
  logic [15:0] miss_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bht_controller #(.ENTRIES(16), .IDX_W(4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .clr           (clr),
    .lookup_pc     (lookup_pc),
    .lookup_ins    (lookup_ins),
    .predict       (predict),
    .pred_state    (pred_state),
    .upd_valid     (upd_valid),
    .upd_pc        (upd_pc),
    .upd_taken     (upd_taken),
    .upd_predicted (upd_predicted),
    .mispredict    (mispredict),
    .ready         (ready),
    .miss_cnt      (miss_cnt)
  );

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n = 1'b0;
    clr = 1'b0;
    upd_valid = 1'b0;
    lookup_ins = INS_BEQ;
    lookup_pc = '0;
    step();
    checks++;
    if (ready !== 1'b0 || mispredict !== 1'b0 ||
        miss_cnt !== 16'd0 || predict !== 1'b0 ||
        pred_state !== 2'b00) begin
      errors++;
      $display("FAIL reset_hold got r=%b m=%b c=%h p=%b s=%b want all 0",
               ready, mispredict, miss_cnt, predict, pred_state);
    end
    rst_n = 1'b1;
    for (int i = 0; i < 16; i++) begin
      checks++;
      if (ready !== 1'b0) begin
        errors++;
        $display("FAIL init_ready cyc %0d got %b want 0", i, ready);
      end
      step();
    end
    checks++;
    if (ready !== 1'b1) begin
      errors++;
      $display("FAIL run_ready got %b want 1", ready);
    end
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      checks++;
      if (pred_state !== 2'b01) begin
        errors++;
        $display("FAIL init_val idx %0d got %b want 01", i, pred_state);
      end
    end
  endtask

  task automatic test_saturate;
    logic [1:0] exp_st [3];
    exp_st[0] = 2'b10;
    exp_st[1] = 2'b11;
    exp_st[2] = 2'b11;
    lookup_pc = 32'h40;
    lookup_ins = INS_BEQ;
    #1;
    checks++;
    if (pred_state !== 2'b01 || predict !== 1'b0) begin
      errors++;
      $display("FAIL sat_start got s=%b p=%b want 01 0", pred_state, predict);
    end
    upd_pc = 32'h40;
    upd_taken = 1'b1;
    upd_predicted = 1'b1;
    for (int i = 0; i < 3; i++) begin
      upd_valid = 1'b1;
      step();
      upd_valid = 1'b0;
      checks++;
      if (pred_state !== exp_st[i] || predict !== 1'b1) begin
        errors++;
        $display("FAIL sat_upd %0d got s=%b p=%b want %b 1",
                 i, pred_state, predict, exp_st[i]);
      end
    end
  endtask

  task automatic test_mispredict;
    upd_pc = 32'h8;
    upd_taken = 1'b0;
    upd_predicted = 1'b1;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b1 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL misp_pulse got m=%b c=%0d want 1 1", mispredict, miss_cnt);
    end
    step();
    checks++;
    if (mispredict !== 1'b0 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL misp_end got m=%b c=%0d want 0 1", mispredict, miss_cnt);
    end
    upd_taken = 1'b1;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b0 || miss_cnt !== 16'd1) begin
      errors++;
      $display("FAIL match_nopulse got m=%b c=%0d want 0 1", mispredict, miss_cnt);
    end
  endtask

  task automatic test_non_beq;
    lookup_pc = 32'h40;
    lookup_ins = INS_J;
    #1;
    checks++;
    if (predict !== 1'b0 || pred_state !== 2'b11) begin
      errors++;
      $display("FAIL non_beq got p=%b s=%b want 0 11", predict, pred_state);
    end
    lookup_ins = INS_BEQ;
  endtask

  task automatic test_same_cycle;
    lookup_pc = 32'h14;
    lookup_ins = INS_BEQ;
    upd_pc = 32'h14;
    upd_taken = 1'b1;
    upd_predicted = 1'b0;
    upd_valid = 1'b1;
    #1;
    checks++;
    if (pred_state !== 2'b01 || predict !== 1'b0) begin
      errors++;
      $display("FAIL same_pre got s=%b p=%b want 01 0", pred_state, predict);
    end
    step();
    upd_valid = 1'b0;
    checks++;
    if (pred_state !== 2'b10 || predict !== 1'b1) begin
      errors++;
      $display("FAIL same_post got s=%b p=%b want 10 1", pred_state, predict);
    end
  endtask

  task automatic test_back_to_back;
    // miss_cnt is 2 here
    upd_pc = 32'h1C;
    upd_taken = 1'b1;
    upd_predicted = 1'b0;
    upd_valid = 1'b1;
    step();
    checks++;
    if (mispredict !== 1'b1 || miss_cnt !== 16'd3) begin
      errors++;
      $display("FAIL b2b_first got m=%b c=%0d want 1 3", mispredict, miss_cnt);
    end
    step();
    upd_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b1 || miss_cnt !== 16'd4) begin
      errors++;
      $display("FAIL b2b_second got m=%b c=%0d want 1 4", mispredict, miss_cnt);
    end
    lookup_pc = 32'h1C;
    #1;
    checks++;
    if (pred_state !== 2'b11) begin
      errors++;
      $display("FAIL b2b_state got %b want 11", pred_state);
    end
    upd_taken = 1'b0;
    upd_predicted = 1'b0;
    upd_valid = 1'b1;
    for (int i = 0; i < 4; i++) step();
    upd_valid = 1'b0;
    checks++;
    if (pred_state !== 2'b00 || miss_cnt !== 16'd4) begin
      errors++;
      $display("FAIL b2b_down got s=%b c=%0d want 00 4", pred_state, miss_cnt);
    end
  endtask

  task automatic test_clr;
    upd_pc = 32'h20;
    upd_taken = 1'b0;
    upd_predicted = 1'b1;
    upd_valid = 1'b1;
    for (int i = 0; i < 3; i++) step();
    upd_valid = 1'b0;
    checks++;
    if (miss_cnt !== 16'd7) begin
      errors++;
      $display("FAIL clr_pre got c=%0d want 7", miss_cnt);
    end
    clr = 1'b1;
    step();
    clr = 1'b0;
    checks++;
    if (ready !== 1'b0 || miss_cnt !== 16'd0 || pred_state !== 2'b00) begin
      errors++;
      $display("FAIL clr_enter got r=%b c=%0d s=%b want 0 0 00",
               ready, miss_cnt, pred_state);
    end
    upd_pc = 32'h0;
    upd_taken = 1'b1;
    upd_predicted = 1'b0;
    upd_valid = 1'b1;
    step();
    upd_valid = 1'b0;
    checks++;
    if (mispredict !== 1'b0 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_ignore got m=%b c=%0d want 0 0", mispredict, miss_cnt);
    end
    for (int i = 0; i < 14; i++) step();
    checks++;
    if (ready !== 1'b0) begin
      errors++;
      $display("FAIL clr_walk got r=%b want 0", ready);
    end
    step();
    checks++;
    if (ready !== 1'b1 || miss_cnt !== 16'd0) begin
      errors++;
      $display("FAIL clr_done got r=%b c=%0d want 1 0", ready, miss_cnt);
    end
    for (int i = 0; i < 16; i++) begin
      lookup_pc = 32'(i) << 2;
      #1;
      checks++;
      if (pred_state !== 2'b01) begin
        errors++;
        $display("FAIL clr_val idx %0d got %b want 01", i, pred_state);
      end
    end
  endtask

  initial begin
    test_reset();
    test_saturate();
    test_mispredict();
    test_non_beq();
    test_same_cycle();
    test_back_to_back();
    test_clr();
    test_saturate();
    test_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
